// File: rtl/dadda_8x8_multiplier_pipe.sv
// Unsigned 8x8 -> 16 pipelined multiplier using a Dadda reduction tree, 3 register stages.
// Optional macro DADDA_VALID_EN adds an in_valid/out_valid sideband that tracks the data.
module dadda_8x8_multiplier_pipe (
  input  logic        clock,
  input  logic        reset_n,
`ifdef DADDA_VALID_EN
  input  logic        in_valid,
  output logic        out_valid,
`endif
  input  logic [7:0]  operand1,
  input  logic [7:0]  operand2,
  output logic [15:0] Result
);

  // Bit matrices are indexed [column][row]; rows are packed from row 0 upward.
  function automatic logic [15:0][3:0] init_heights();
    logic [15:0][3:0] h;
    h = '0;
    for (int i = 0; i < 16; i++) begin
      h[i] = (i < 8) ? 4'(i + 1) : 4'(15 - i);
    end
    return h;
  endfunction

  // Column heights after one Dadda step towards target height d.
  function automatic logic [15:0][3:0] next_heights(input logic [15:0][3:0] h_in, input int d);
    logic [15:0][3:0] h_out;
    int               h;
    int               n_prev;
    int               n_cur;
    h_out  = '0;
    n_prev = 0;
    for (int i = 0; i < 16; i++) begin
      h     = int'(h_in[i]) + n_prev;
      n_cur = 0;
      for (int k = 0; k < 8; k++) begin
        if (h > d) begin
          h     = (h == d + 1) ? h - 1 : h - 2;
          n_cur = n_cur + 1;
        end
      end
      h_out[i] = 4'(h);
      n_prev   = n_cur;
    end
    return h_out;
  endfunction

  function automatic logic [15:0][7:0] pp_matrix(input logic [7:0] a, input logic [7:0] b);
    logic [15:0][7:0] m;
    logic [15:0][3:0] fill;
    m    = '0;
    fill = '0;
    for (int j = 0; j < 8; j++) begin
      for (int k = 0; k < 8; k++) begin
        m[j+k][fill[j+k][2:0]] = a[j] & b[k];
        fill[j+k]              = fill[j+k] + 4'd1;
      end
    end
    return m;
  endfunction

  // One Dadda step: only as many full/half adders as needed to bring each column down to d,
  // counting the carries arriving from the column to the right.
  function automatic logic [15:0][7:0] dadda_step(input logic [15:0][7:0] m_in,
                                                  input logic [15:0][3:0] h_in,
                                                  input int               d);
    logic [15:0][7:0] m_out;
    logic [7:0]       c_prev;
    logic [7:0]       c_cur;
    logic             x0;
    logic             x1;
    logic             x2;
    int               n_prev;
    int               n_cur;
    int               h;
    int               hi;
    int               idx;
    int               o;
    m_out  = '0;
    c_prev = '0;
    n_prev = 0;
    for (int i = 0; i < 16; i++) begin
      hi    = int'(h_in[i]);
      h     = hi + n_prev;
      idx   = 0;
      o     = 0;
      n_cur = 0;
      c_cur = '0;
      for (int k = 0; k < 8; k++) begin
        if (h > d) begin
          x0 = m_in[i][idx];
          x1 = m_in[i][idx+1];
          if (h == d + 1) begin
            m_out[i][o]  = x0 ^ x1;
            c_cur[n_cur] = x0 & x1;
            idx          = idx + 2;
            h            = h - 1;
          end else begin
            x2           = m_in[i][idx+2];
            m_out[i][o]  = x0 ^ x1 ^ x2;
            c_cur[n_cur] = (x0 & x1) | (x2 & (x0 ^ x1));
            idx          = idx + 3;
            h            = h - 2;
          end
          o     = o + 1;
          n_cur = n_cur + 1;
        end
      end
      for (int j = 0; j < 8; j++) begin
        if (j >= idx && j < hi) begin
          m_out[i][o] = m_in[i][j];
          o           = o + 1;
        end
      end
      for (int j = 0; j < 8; j++) begin
        if (j < n_prev) begin
          m_out[i][o] = c_prev[j];
          o           = o + 1;
        end
      end
      c_prev = c_cur;
      n_prev = n_cur;
    end
    return m_out;
  endfunction

  logic [7:0]       op_a_q, op_a_d;
  logic [7:0]       op_b_q, op_b_d;
  logic [15:0][3:0] rows_q, rows_d;
  logic [15:0]      result_q, result_d;

  logic [15:0][3:0] h8, h6, h4, h3, h2;
  logic [15:0][7:0] m8, m6, m4;
  logic [15:0][7:0] r4, r3, r2;
  logic [15:0]      row_a, row_b;
  logic             carry;

  // Height profile is structural: constant after elaboration.
  always_comb begin
    h8 = init_heights();
    h6 = next_heights(h8, 6);
    h4 = next_heights(h6, 4);
    h3 = next_heights(h4, 3);
    h2 = next_heights(h3, 2);
  end

  always_comb begin
    op_a_d = operand1;
    op_b_d = operand2;
  end

  // Stage 2: partial products, 8 -> 6 -> 4.
  always_comb begin
    m8     = pp_matrix(op_a_q, op_b_q);
    m6     = dadda_step(m8, h8, 6);
    m4     = dadda_step(m6, h6, 4);
    rows_d = '0;
    for (int i = 0; i < 16; i++) begin
      rows_d[i] = m4[i][3:0];
    end
  end

  // Stage 3: 4 -> 3 -> 2, then ripple carry-propagate adder.
  always_comb begin
    r4 = '0;
    for (int i = 0; i < 16; i++) begin
      r4[i][3:0] = rows_q[i];
    end
    r3    = dadda_step(r4, h4, 3);
    r2    = dadda_step(r3, h3, 2);
    row_a = '0;
    row_b = '0;
    for (int i = 0; i < 16; i++) begin
      row_a[i] = r2[i][0];
      row_b[i] = r2[i][1];
    end
    carry    = 1'b0;
    result_d = '0;
    for (int i = 0; i < 16; i++) begin
      result_d[i] = row_a[i] ^ row_b[i] ^ carry;
      carry       = (row_a[i] & row_b[i]) | (carry & (row_a[i] ^ row_b[i]));
    end
  end

  // reset_n is active-high despite its name.
  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      rows_q   <= '0;
      result_q <= '0;
    end else begin
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      rows_q   <= rows_d;
      result_q <= result_d;
    end
  end

  assign Result = result_q;

`ifdef DADDA_VALID_EN
  logic [2:0] valid_q, valid_d;

  always_comb begin
    valid_d = {valid_q[1:0], in_valid};
  end

  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q[2];
`endif

endmodule

// File: tb/tb_dadda_8x8_multiplier_pipe.sv
// Self-checking bench: fixed vectors, sweep, reset corners and all 65536 pairs in random order.
module tb_dadda_8x8_multiplier_pipe;

  logic        clock;
  logic        reset_n;
  logic [7:0]  operand1;
  logic [7:0]  operand2;
  logic [15:0] Result;
`ifdef DADDA_VALID_EN
  logic        in_valid;
  logic        out_valid;
`endif

  dadda_8x8_multiplier_pipe dut (
    .clock    (clock),
    .reset_n  (reset_n),
`ifdef DADDA_VALID_EN
    .in_valid (in_valid),
    .out_valid(out_valid),
`endif
    .operand1 (operand1),
    .operand2 (operand2),
    .Result   (Result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  int n_cmp;
  int n_fail;

  // Reference: products of pairs sampled on each edge out of reset; Result shows the oldest of 3.
  logic [15:0] prod_q[$];
  logic        vld_q[$];

  logic [15:0] perm [65536];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  task automatic model_clear();
    prod_q.delete();
    vld_q.delete();
  endtask

  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic v);
    logic [15:0] exp_p;
    logic        exp_v;
    operand1 = a;
    operand2 = b;
`ifdef DADDA_VALID_EN
    in_valid = v;
`endif
    @(posedge clock);
    if (reset_n == 1'b0) begin
      prod_q.push_back(16'(int'(a) * int'(b)));
      vld_q.push_back(v);
      if (prod_q.size() > 3) begin
        void'(prod_q.pop_front());
        void'(vld_q.pop_front());
      end
    end
    #1;
    exp_p = (prod_q.size() == 3) ? prod_q[0] : 16'd0;
    exp_v = (vld_q.size() == 3) ? vld_q[0] : 1'b0;
    check("pipe_result", Result, exp_p);
`ifdef DADDA_VALID_EN
    check("pipe_out_valid", {15'd0, out_valid}, {15'd0, exp_v});
`else
    if (exp_v) begin end
`endif
  endtask

  initial begin
    vec_t        vecs [5];
    logic [7:0]  mid_a [3];
    logic [7:0]  mid_b [3];
    logic [15:0] tmp;
    int          j;

    n_cmp  = 0;
    n_fail = 0;
    vecs[0] = '{a: 8'd0,   b: 8'd255, p: 16'd0};
    vecs[1] = '{a: 8'd255, b: 8'd255, p: 16'd65025};
    vecs[2] = '{a: 8'd128, b: 8'd2,   p: 16'd256};
    vecs[3] = '{a: 8'd127, b: 8'd128, p: 16'd16256};
    vecs[4] = '{a: 8'd1,   b: 8'd1,   p: 16'd1};

    // Held reset with non-zero operands and a running clock.
    reset_n  = 1'b1;
    operand1 = 8'd200;
    operand2 = 8'd200;
`ifdef DADDA_VALID_EN
    in_valid = 1'b1;
`endif
    model_clear();
    repeat (4) begin
      @(posedge clock);
      #1;
      check("reset_hold", Result, 16'd0);
`ifdef DADDA_VALID_EN
      check("reset_hold_valid", {15'd0, out_valid}, 16'd0);
`endif
    end
    #3;
    reset_n = 1'b0;

    // Single products, each held for 3 edges.
    for (int i = 0; i < 5; i++) begin
      repeat (3) step(vecs[i].a, vecs[i].b, 1'b1);
      check($sformatf("single_%0dx%0d", vecs[i].a, vecs[i].b), Result, vecs[i].p);
    end

    // Back-to-back sweep.
    for (int i = 0; i < 255; i++) begin
      step(8'(i), 8'(255 - i), 1'b1);
      if (i == 3) check("sweep_1x254", Result, 16'd254);
      if (i == 102) check("sweep_100x155", Result, 16'd15500);
    end

    // Mid-stream reset: three pairs in flight, short pulse between edges.
    mid_a[0] = 8'd17;  mid_b[0] = 8'd99;
    mid_a[1] = 8'd250; mid_b[1] = 8'd3;
    mid_a[2] = 8'd64;  mid_b[2] = 8'd64;
    for (int i = 0; i < 3; i++) step(mid_a[i], mid_b[i], 1'b1);
    #2;
    reset_n = 1'b1;
    #1;
    check("async_reset_drop", Result, 16'd0);
`ifdef DADDA_VALID_EN
    check("async_reset_valid", {15'd0, out_valid}, 16'd0);
`endif
    model_clear();
    #2;
    reset_n = 1'b0;
    step(8'd9, 8'd11, 1'b1);
    check("post_reset_0", Result, 16'd0);
    step(8'd12, 8'd13, 1'b1);
    check("post_reset_1", Result, 16'd0);
    step(8'd14, 8'd15, 1'b1);
    check("post_reset_first", Result, 16'd99);
    step(8'd0, 8'd0, 1'b1);
    check("post_reset_second", Result, 16'd156);

`ifdef DADDA_VALID_EN
    // Valid pattern 1,0,1,1 followed by idle cycles.
    step(8'($urandom), 8'($urandom), 1'b1);
    step(8'($urandom), 8'($urandom), 1'b0);
    step(8'($urandom), 8'($urandom), 1'b1);
    step(8'($urandom), 8'($urandom), 1'b1);
    repeat (4) step(8'($urandom), 8'($urandom), 1'b0);
`endif

    // All operand pairs, shuffled.
    for (int i = 0; i < 65536; i++) perm[i] = 16'(i);
    for (int i = 65535; i > 0; i--) begin
      j       = int'($urandom_range(i, 0));
      tmp     = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
    for (int i = 0; i < 65536; i++) begin
      step(perm[i][15:8], perm[i][7:0], 1'($urandom));
    end
    repeat (3) step(8'd0, 8'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
